// File: rtl/psg_nch_pkg.sv
// psg_nch_pkg: shared constants for the programmable sound generator.
// Holds the log volume table, register map, envelope shape bit positions
// and the channel-count range check.
package psg_nch_pkg;

  // 32-step log volume curve, strictly increasing, full scale at index 31
  localparam logic [7:0] VOL_TBL [32] = '{
    8'd0,   8'd1,   8'd2,   8'd3,   8'd4,   8'd5,   8'd6,   8'd7,
    8'd9,   8'd11,  8'd13,  8'd15,  8'd18,  8'd21,  8'd25,  8'd29,
    8'd34,  8'd40,  8'd47,  8'd55,  8'd64,  8'd75,  8'd88,  8'd103,
    8'd120, 8'd140, 8'd160, 8'd180, 8'd200, 8'd220, 8'd238, 8'd255
  };

  localparam logic [5:0] A_NPER    = 6'h20;
  localparam logic [5:0] A_TDIS    = 6'h21;
  localparam logic [5:0] A_NDIS    = 6'h22;
  localparam logic [5:0] A_VOL     = 6'h28;
  localparam logic [5:0] A_EPER_LO = 6'h30;
  localparam logic [5:0] A_EPER_HI = 6'h31;
  localparam logic [5:0] A_ESHAPE  = 6'h32;
  localparam logic [5:0] A_PAN     = 6'h38;

  localparam int SH_HOLD = 0;
  localparam int SH_ALT  = 1;
  localparam int SH_ATT  = 2;
  localparam int SH_CONT = 3;

  function automatic bit num_ch_ok(input int n);
    return (n >= 1) && (n <= 8);
  endfunction

endpackage

// File: rtl/psg_nch_tone.sv
// psg_nch_tone: one square-wave tone channel. A 12-bit up-counter advanced
// on each prescaler tick toggles the output when it reaches period-1.
// The >= compare lets a shortened period wrap on the very next tick.
module psg_nch_tone (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic [11:0] period,
  output logic        tone
);

  logic [11:0] cnt;
  logic [11:0] per_m1;

  // period 0 behaves as period 1
  assign per_m1 = (period == 12'd0) ? 12'd0 : period - 12'd1;

  // counter and toggle, stepped only on ticks
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      tone <= 1'b0;
    end else if (tick) begin
      if (cnt >= per_m1) begin
        cnt  <= '0;
        tone <= ~tone;
      end else begin
        cnt <= cnt + 12'd1;
      end
    end
  end

endmodule

// File: rtl/psg_nch.sv
// psg_nch: NUM_CH-channel sound generator with shared noise and envelope,
// register port, per-channel log levels and mixed outputs.
// Optional stereo panning is compiled in with the macro PSG_NCH_PAN_EN.
module psg_nch
  import psg_nch_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int OUT_W  = 8
) (
  input  logic                                CLK,
  input  logic                                RESET,
  input  logic                                CE,
  input  logic                                SEL,
  input  logic                                WE,
  input  logic                                RD,
  input  logic [5:0]                          ADDR,
  input  logic [7:0]                          DI,
  output logic [7:0]                          DO,
  output logic [NUM_CH*OUT_W-1:0]             CH,
  output logic [OUT_W+$clog2(NUM_CH+1)-1:0]   MIX_L,
  output logic [OUT_W+$clog2(NUM_CH+1)-1:0]   MIX_R,
  output logic [NUM_CH-1:0]                   ACTIVE
);

  localparam int MIX_W = OUT_W + $clog2(NUM_CH + 1);

  if (!num_ch_ok(NUM_CH)) begin : g_bad_num_ch
    $error("psg_nch: NUM_CH must be 1..8");
  end

  logic [11:0] tper [NUM_CH];
  logic [4:0]  vol  [NUM_CH];
  logic [4:0]  nper;
  logic [7:0]  tdis, ndis;
  logic [15:0] eper;
  logic [3:0]  eshape;
`ifdef PSG_NCH_PAN_EN
  logic [1:0]  pan  [NUM_CH];
`endif

  // register file writes; masks reset to all ones so the block starts silent
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < NUM_CH; i++) begin
        tper[i] <= '0;
        vol[i]  <= '0;
`ifdef PSG_NCH_PAN_EN
        pan[i]  <= 2'b11;
`endif
      end
      nper   <= '0;
      tdis   <= 8'hFF;
      ndis   <= 8'hFF;
      eper   <= '0;
      eshape <= '0;
    end else if (WE) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ADDR == 6'(2*i))       tper[i][7:0]  <= DI;
        if (ADDR == 6'(2*i + 1))   tper[i][11:8] <= DI[3:0];
        if (ADDR == A_VOL + 6'(i)) vol[i]        <= DI[4:0];
`ifdef PSG_NCH_PAN_EN
        if (ADDR == A_PAN + 6'(i)) pan[i]        <= DI[1:0];
`endif
      end
      case (ADDR)
        A_NPER:    nper        <= DI[4:0];
        A_TDIS:    tdis        <= DI;
        A_NDIS:    ndis        <= DI;
        A_EPER_LO: eper[7:0]   <= DI;
        A_EPER_HI: eper[15:8]  <= DI;
        A_ESHAPE:  eshape      <= DI[3:0];
        default: ;
      endcase
    end
  end

  logic [7:0] rdata;

  // read mux; anything not decoded reads 0xFF
  always_comb begin
    rdata = 8'hFF;
    case (ADDR)
      A_NPER:    rdata = {3'b000, nper};
      A_TDIS:    rdata = tdis;
      A_NDIS:    rdata = ndis;
      A_EPER_LO: rdata = eper[7:0];
      A_EPER_HI: rdata = eper[15:8];
      A_ESHAPE:  rdata = {4'h0, eshape};
      default: ;
    endcase
    for (int i = 0; i < NUM_CH; i++) begin
      if (ADDR == 6'(2*i))       rdata = tper[i][7:0];
      if (ADDR == 6'(2*i + 1))   rdata = {4'h0, tper[i][11:8]};
      if (ADDR == A_VOL + 6'(i)) rdata = {3'b000, vol[i]};
`ifdef PSG_NCH_PAN_EN
      if (ADDR == A_PAN + 6'(i)) rdata = {6'd0, pan[i]};
`endif
    end
  end

  // registered read data; a same-cycle write is not yet visible here
  always_ff @(posedge CLK) begin
    if (RESET)   DO <= 8'hFF;
    else if (RD) DO <= rdata;
  end

  logic [3:0] pre_cnt;
  logic       noise_div;
  logic       tick, noise_tick;

  assign tick       = CE && (pre_cnt == (SEL ? 4'd15 : 4'd7));
  assign noise_tick = tick && noise_div;

  // CE prescaler: one tick per 8 or 16 CE, noise runs at half that rate
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pre_cnt   <= '0;
      noise_div <= 1'b0;
    end else if (CE) begin
      pre_cnt <= tick ? 4'd0 : pre_cnt + 4'd1;
      if (tick) noise_div <= ~noise_div;
    end
  end

  logic [4:0]  n_cnt, nper_m1;
  logic [16:0] lfsr;
  logic        noise;

  assign nper_m1 = (nper == 5'd0) ? 5'd0 : nper - 5'd1;
  assign noise   = lfsr[0];

  // noise period counter and 17-bit LFSR (taps 0 and 3)
  always_ff @(posedge CLK) begin
    if (RESET) begin
      n_cnt <= '0;
      lfsr  <= 17'd1;
    end else if (noise_tick) begin
      if (n_cnt >= nper_m1) begin
        n_cnt <= '0;
        lfsr  <= {lfsr[0] ^ lfsr[3], lfsr[16:1]};
      end else begin
        n_cnt <= n_cnt + 5'd1;
      end
    end
  end

  logic [15:0] env_cnt, eper_m1;
  logic        env_step, env_restart;
  logic [4:0]  env_lvl;
  logic        env_up, env_hold;
  logic        env_end;

  assign eper_m1     = (eper == 16'd0) ? 16'd0 : eper - 16'd1;
  assign env_step    = tick && (env_cnt >= eper_m1);
  assign env_restart = WE && (ADDR == A_ESHAPE);
  assign env_end     = env_up ? (env_lvl == 5'd31) : (env_lvl == 5'd0);

  // envelope generator; a shape write restarts it and beats a coincident step
  always_ff @(posedge CLK) begin
    if (RESET) begin
      env_cnt  <= '0;
      env_lvl  <= 5'd31;
      env_up   <= 1'b0;
      env_hold <= 1'b0;
    end else if (env_restart) begin
      env_cnt  <= '0;
      env_lvl  <= DI[SH_ATT] ? 5'd0 : 5'd31;
      env_up   <= DI[SH_ATT];
      env_hold <= 1'b0;
    end else if (tick) begin
      env_cnt <= env_step ? 16'd0 : env_cnt + 16'd1;
      if (env_step && !env_hold) begin
        if (env_end) begin
          if (!eshape[SH_CONT]) begin
            env_lvl  <= 5'd0;
            env_hold <= 1'b1;
          end else if (eshape[SH_HOLD]) begin
            env_hold <= 1'b1;
            if (eshape[SH_ALT]) env_lvl <= ~env_lvl;
          end else if (eshape[SH_ALT]) begin
            env_up  <= ~env_up;
            env_lvl <= env_up ? env_lvl - 5'd1 : env_lvl + 5'd1;
          end else begin
            env_lvl <= env_up ? 5'd0 : 5'd31;
          end
        end else begin
          env_lvl <= env_up ? env_lvl + 5'd1 : env_lvl - 5'd1;
        end
      end
    end
  end

  logic [NUM_CH-1:0]            tone, gate;
  logic [NUM_CH-1:0][4:0]       idx;
  logic [NUM_CH-1:0][OUT_W-1:0] lvl_out;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    psg_nch_tone u_tone (
      .clk    (CLK),
      .reset  (RESET),
      .tick   (tick),
      .period (tper[i]),
      .tone   (tone[i])
    );
    assign gate[i]    = (tone[i] | tdis[i]) & (noise | ndis[i]);
    assign idx[i]     = !gate[i] ? 5'd0 :
                        (vol[i][4] ? env_lvl : {vol[i][3:0], vol[i][3]});
    assign lvl_out[i] = OUT_W'(VOL_TBL[idx[i]]) << (OUT_W - 8);
  end

  assign ACTIVE = ~(tdis[NUM_CH-1:0] & ndis[NUM_CH-1:0]);

  logic [MIX_W-1:0] mix_l_d, mix_r_d;

  // full-width channel sums, so no saturation is needed
  always_comb begin
    mix_l_d = '0;
    mix_r_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
`ifdef PSG_NCH_PAN_EN
      if (pan[i][0]) mix_l_d = mix_l_d + MIX_W'(lvl_out[i]);
      if (pan[i][1]) mix_r_d = mix_r_d + MIX_W'(lvl_out[i]);
`else
      mix_l_d = mix_l_d + MIX_W'(lvl_out[i]);
      mix_r_d = mix_r_d + MIX_W'(lvl_out[i]);
`endif
    end
  end

  // output registers for channel levels and mixes
  always_ff @(posedge CLK) begin
    if (RESET) begin
      CH    <= '0;
      MIX_L <= '0;
      MIX_R <= '0;
    end else begin
      CH    <= lvl_out;
      MIX_L <= mix_l_d;
      MIX_R <= mix_r_d;
    end
  end

endmodule
